// File: rtl/xbutton_array_pkg.sv
// Shared definitions for the push-button peripheral: bus width, register map, helpers.
// Optional interrupt support is selected in the top level by XBUTTON_IRQ_EN.
`ifndef DATA_W
`define DATA_W 16
`endif

package xbutton_array_pkg;

   localparam int unsigned DATA_W = `DATA_W;

   typedef enum logic [1:0] {
      BTN_LEVEL    = 2'd0,
      BTN_PRESS    = 2'd1,
      BTN_RELEASE  = 2'd2,
      BTN_IRQ_MASK = 2'd3
   } btn_reg_e;

   // Counter must be able to hold DEB_CYCLES-1; +1 keeps DEB_CYCLES==1 at one bit.
   function automatic int unsigned cnt_width(input int unsigned deb_cycles);
      return (deb_cycles < 2) ? 1 : $clog2(deb_cycles + 1);
   endfunction

endpackage

// File: rtl/xbutton_debounce.sv
// One button channel: 2-flop synchroniser, stable-count debouncer, edge pulses.
// Independent of XBUTTON_IRQ_EN.
module xbutton_debounce
   import xbutton_array_pkg::*;
#(
   parameter int unsigned DEB_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst,
   input  logic bt_raw,
   output logic lvl,
   output logic rise,
   output logic fall
);

   localparam int unsigned      CNT_W    = cnt_width(DEB_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

   logic [1:0]       sync_q, sync_d;
   logic             lvl_q, lvl_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             s;
   logic             expire;

   // rise/fall fire in the cycle the level is about to flip, so sticky flags
   // set on the same edge that updates lvl.
   always_comb begin
      sync_d = {sync_q[0], bt_raw};
      s      = sync_q[1];
      expire = (s != lvl_q) && (cnt_q == CNT_LAST);
      lvl_d  = lvl_q;
      cnt_d  = '0;
      if (s != lvl_q) begin
         if (expire) begin
            lvl_d = s;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
      rise = expire & s;
      fall = expire & ~s;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         sync_q <= '0;
         lvl_q  <= 1'b0;
         cnt_q  <= '0;
      end else begin
         sync_q <= sync_d;
         lvl_q  <= lvl_d;
         cnt_q  <= cnt_d;
      end
   end

   assign lvl = lvl_q;

endmodule

// File: rtl/xbutton_array.sv
// N-channel debounced button peripheral with sticky W1C press/release flags.
// Define XBUTTON_IRQ_EN to add the IRQ_MASK register and the registered irq output.
`ifndef DATA_W
`define DATA_W 16
`endif

module xbutton_array
   import xbutton_array_pkg::*;
#(
   parameter int unsigned N_BT       = 4,
   parameter int unsigned DEB_CYCLES = 500000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               sel,
   input  logic               we,
   input  logic [1:0]         addr,
   input  logic [`DATA_W-1:0] data_in,
   output logic [`DATA_W-1:0] data_out,
   input  logic [N_BT-1:0]    bt
`ifdef XBUTTON_IRQ_EN
   ,
   output logic               irq
`endif
);

   logic [N_BT-1:0] lvl, rise, fall;
   logic [N_BT-1:0] press_q, press_d;
   logic [N_BT-1:0] rel_q, rel_d;
   logic [N_BT-1:0] press_clr, rel_clr;
   logic [N_BT-1:0] wr_bits;
   logic [N_BT-1:0] mask_rd;
   logic            wr_en;
   btn_reg_e        reg_sel;
   logic            data_in_unused;

   genvar g;
   generate
      for (g = 0; g < N_BT; g++) begin : g_ch
         xbutton_debounce #(
            .DEB_CYCLES(DEB_CYCLES)
         ) u_deb (
            .clk   (clk),
            .rst   (rst),
            .bt_raw(bt[g]),
            .lvl   (lvl[g]),
            .rise  (rise[g]),
            .fall  (fall[g])
         );
      end
   endgenerate

   assign reg_sel        = btn_reg_e'(addr);
   assign wr_en          = sel & we;
   assign wr_bits        = data_in[N_BT-1:0];
   assign data_in_unused = ^data_in;

   // A set in the same cycle as a W1C of that bit wins.
   always_comb begin
      press_clr = '0;
      rel_clr   = '0;
      if (wr_en && reg_sel == BTN_PRESS)   press_clr = wr_bits;
      if (wr_en && reg_sel == BTN_RELEASE) rel_clr   = wr_bits;
      press_d = (press_q & ~press_clr) | rise;
      rel_d   = (rel_q & ~rel_clr) | fall;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         press_q <= '0;
         rel_q   <= '0;
      end else begin
         press_q <= press_d;
         rel_q   <= rel_d;
      end
   end

`ifdef XBUTTON_IRQ_EN
   logic [N_BT-1:0] mask_q, mask_d;
   logic            irq_q, irq_d;

   always_comb begin
      mask_d = mask_q;
      if (wr_en && reg_sel == BTN_IRQ_MASK) mask_d = wr_bits;
      irq_d = |((press_q | rel_q) & mask_q);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         mask_q <= '0;
         irq_q  <= 1'b0;
      end else begin
         mask_q <= mask_d;
         irq_q  <= irq_d;
      end
   end

   assign mask_rd = mask_q;
   assign irq     = irq_q;
`else
   assign mask_rd = '0;
`endif

   always_comb begin
      data_out = '0;
      if (sel) begin
         unique case (reg_sel)
            BTN_LEVEL:    data_out = DATA_W'(lvl);
            BTN_PRESS:    data_out = DATA_W'(press_q);
            BTN_RELEASE:  data_out = DATA_W'(rel_q);
            BTN_IRQ_MASK: data_out = DATA_W'(mask_rd);
            default:      data_out = '0;
         endcase
      end
   end

endmodule
